// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises, debounces and arbitrates the raw dime/nickel sensor
// lines into one-cycle D/N pulses. Define COIN_TALLY_EN to add the total_cents tally.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dime_raw,
  input  logic       nickel_raw,
  input  logic       busy,
  output logic       D,
  output logic       N
`ifdef COIN_TALLY_EN
  ,
  output logic [7:0] total_cents
`endif
);

  // Channel index 0 is nickel, 1 is dime.
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       stable;
  logic [1:0]       stable_q;
  logic [1:0]       pending;
  logic [1:0]       rise;
  logic [1:0]       issue;
  logic [CNT_W-1:0] cnt [2];

  assign raw  = {dime_raw, nickel_raw};
  assign rise = stable & ~stable_q;

  // Nickel wins when both are pending; busy holds everything.
  always_comb begin
    issue = '0;
    if (!busy) begin
      if (pending[0])      issue[0] = 1'b1;
      else if (pending[1]) issue[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      pending  <= '0;
      D        <= 1'b0;
      N        <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      // Toggling on the DEBOUNCE_CYCLES-th mismatch is the same as toggling when
      // the count of mismatches reaches DEBOUNCE_CYCLES.
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      pending <= (pending & ~issue) | rise;
      N       <= issue[0];
      D       <= issue[1];
    end
  end

`ifdef COIN_TALLY_EN
  logic [8:0] tally_sum;

  always_comb begin
    tally_sum = {1'b0, total_cents};
    if (issue[0])      tally_sum = tally_sum + 9'd5;
    else if (issue[1]) tally_sum = tally_sum + 9'd10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) total_cents <= '0;
    else      total_cents <= tally_sum[8] ? 8'hFF : tally_sum[7:0];
  end
`endif

endmodule
